// File: rtl/lbp_mem_server_if.sv
// Bus bundle between lbp_mem_server and its host/engine side.
// The slave modport is the server; the master modport is the host plus engine.
interface lbp_mem_server_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
);
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;
   logic              gray_req;
   logic [ADDR_W-1:0] gray_addr;
   logic [DATA_W-1:0] gray_data;
   logic              lbp_write;
   logic [ADDR_W-1:0] lbp_addr;
   logic [DATA_W-1:0] lbp_data;
   logic              finish;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              clear;
   logic              done;
   logic              err_border;
   logic              err_dup;
   logic              err_count;

   modport slave (
      input  load_valid, load_data, gray_req, gray_addr, lbp_write, lbp_addr,
             lbp_data, finish, out_ready, clear,
      output load_ready, gray_data, out_valid, out_addr, out_data, done,
             err_border, err_dup, err_count
   );

   modport master (
      output load_valid, load_data, gray_req, gray_addr, lbp_write, lbp_addr,
             lbp_data, finish, out_ready, clear,
      input  load_ready, gray_data, out_valid, out_addr, out_data, done,
             err_border, err_dup, err_count
   );
endinterface

// File: rtl/lbp_mem_server.sv
// Gray-image source and LBP-result sink for the LBP engine.
// Loads an 8x8 image, serves reads, captures result writes, then streams the result back.
module lbp_mem_server #(
   parameter int IMG_DIM = 8,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 8
) (
   input  logic            clk,
   input  logic            reset,
   lbp_mem_server_if.slave bus
);
   localparam int                DEPTH     = IMG_DIM * IMG_DIM;
   localparam int                CRD_W     = ADDR_W / 2;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [6:0]        WR_SAT    = 7'(DEPTH);
   localparam logic [6:0]        WR_EXPECT = 7'((IMG_DIM - 2) * (IMG_DIM - 2));

   typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DUMP, S_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_gray_mem [DEPTH];
   logic [DATA_W-1:0] r_lbp_mem  [DEPTH];
   logic [DEPTH-1:0]  r_wr_mask;
   logic [6:0]        r_wr_count, w_wr_count_nxt;
   logic [ADDR_W-1:0] r_load_cnt, r_last_addr, r_out_addr;
   logic              r_wr_prev;
   logic [DATA_W-1:0] r_gray_data;
   logic              r_err_border, r_err_dup, r_err_count;
   logic              w_serve, w_load_fire, w_load_last, w_out_fire, w_out_last;
   logic              w_wr_en, w_wr_border, w_wr_new, w_wr_first;
   logic              w_load_ready, w_out_valid, w_done;

   function automatic logic is_border(input logic [ADDR_W-1:0] a);
      logic [CRD_W-1:0] x, y;
      x = a[CRD_W-1:0];
      y = a[ADDR_W-1:CRD_W];
      return (x == '0) || (x == CRD_W'(IMG_DIM - 1)) ||
             (y == '0) || (y == CRD_W'(IMG_DIM - 1));
   endfunction

   assign w_serve     = (r_state == S_SERVE);
   assign w_load_fire = (r_state == S_LOAD) && bus.load_valid;
   assign w_load_last = w_load_fire && (r_load_cnt == LAST_ADDR);
   assign w_out_fire  = (r_state == S_DUMP) && bus.out_ready;
   assign w_out_last  = w_out_fire && (r_out_addr == LAST_ADDR);

   // A held strobe only counts again when the address moves.
   assign w_wr_en     = w_serve && bus.lbp_write;
   assign w_wr_border = is_border(bus.lbp_addr);
   assign w_wr_new    = w_wr_en && !w_wr_border &&
                        (!r_wr_prev || (bus.lbp_addr != r_last_addr));
   assign w_wr_first  = w_wr_new && !r_wr_mask[bus.lbp_addr];
   assign w_wr_count_nxt = (w_wr_first && (r_wr_count != WR_SAT)) ?
                           r_wr_count + 7'd1 : r_wr_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_LOAD;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_LOAD:  if (w_load_last) w_state_nxt = S_SERVE;
         S_SERVE: if (bus.finish)  w_state_nxt = S_DUMP;
         S_DUMP:  if (w_out_last)  w_state_nxt = S_DONE;
         S_DONE:  if (bus.clear)   w_state_nxt = S_LOAD;
         default: w_state_nxt = S_LOAD;
      endcase
   end

   always_comb begin
      w_load_ready = 1'b0;
      w_out_valid  = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_LOAD:  w_load_ready = 1'b1;
         S_DUMP:  w_out_valid  = 1'b1;
         S_DONE:  w_done       = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_load_fire)                r_gray_mem[r_load_cnt]   <= bus.load_data;
      if (w_wr_en && !w_wr_border)    r_lbp_mem[bus.lbp_addr]  <= bus.lbp_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_load_cnt   <= '0;
         r_wr_mask    <= '0;
         r_wr_count   <= '0;
         r_last_addr  <= '0;
         r_wr_prev    <= 1'b0;
         r_gray_data  <= '0;
         r_out_addr   <= '0;
         r_err_border <= 1'b0;
         r_err_dup    <= 1'b0;
         r_err_count  <= 1'b0;
      end else begin
         if (w_load_fire) r_load_cnt <= r_load_cnt + ADDR_W'(1);
         if (w_load_last) begin
            r_load_cnt   <= '0;
            r_wr_mask    <= '0;
            r_wr_count   <= '0;
            r_last_addr  <= '0;
            r_wr_prev    <= 1'b0;
            r_err_border <= 1'b0;
            r_err_dup    <= 1'b0;
            r_err_count  <= 1'b0;
         end
         if (w_serve) begin
            r_wr_prev  <= bus.lbp_write;
            r_wr_count <= w_wr_count_nxt;
            if (bus.gray_req) r_gray_data <= r_gray_mem[bus.gray_addr];
            if (w_wr_en) begin
               r_last_addr <= bus.lbp_addr;
               if (w_wr_border) r_err_border <= 1'b1;
            end
            if (w_wr_new) begin
               if (r_wr_mask[bus.lbp_addr]) r_err_dup <= 1'b1;
               else                         r_wr_mask[bus.lbp_addr] <= 1'b1;
            end
            // Uses the post-write count so a write landing with finish is included.
            if (bus.finish && (w_wr_count_nxt != WR_EXPECT)) r_err_count <= 1'b1;
         end
         if (w_out_fire) r_out_addr <= r_out_addr + ADDR_W'(1);
      end
   end

   assign bus.load_ready = w_load_ready;
   assign bus.gray_data  = r_gray_data;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_addr   = r_out_addr;
   assign bus.out_data   = (r_wr_mask[r_out_addr] && !is_border(r_out_addr)) ?
                           r_lbp_mem[r_out_addr] : '0;
   assign bus.done       = w_done;
   assign bus.err_border = r_err_border;
   assign bus.err_dup    = r_err_dup;
   assign bus.err_count  = r_err_count;
endmodule

// File: doc/lbp_mem_server.md
# lbp_mem_server

Memory-side responder for the LBP engine's gray-image read port and LBP-result write port. Holds the 8×8 source image loaded by the host and serves the engine's registered read requests. Captures the engine's result writes. When the engine raises `finish`, streams the 64-entry result image back to the host with a valid/ready handshake, forcing border and unwritten pixels to 0. Sits between the host/testbench and the LBP engine, replacing behavioural gray and LBP memories.

## Interface
- `IMG_DIM`, 8, image side length; depth = `IMG_DIM*IMG_DIM` = 64.
- `ADDR_W`, 6, address width; address = {y[2:0], x[2:0]}.
- `DATA_W`, 8, pixel width.

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high
- `load_valid`  in  1  host image byte valid
- `load_data`  in  8  host image byte, raster order
- `load_ready`  out  1  block accepts image bytes
- `gray_req`  in  1  engine read request
- `gray_addr`  in  6  engine read address
- `gray_data`  out  8  read data returned to engine
- `lbp_write`  in  1  engine write strobe (level)
- `lbp_addr`  in  6  engine write address
- `lbp_data`  in  8  engine write data
- `finish`  in  1  engine completion
- `out_valid`  out  1  result byte valid
- `out_addr`  out  6  result address
- `out_data`  out  8  result byte
- `out_ready`  in  1  host accepts result byte
- `clear`  in  1  return from DONE to LOAD
- `done`  out  1  dump complete, held
- `err_border`  out  1  sticky: write to border address
- `err_dup`  out  1  sticky: interior address written twice
- `err_count`  out  1  sticky: finish with interior write count ≠ 36

## Operation
- States: LOAD (reset), SERVE, DUMP, DONE.
- LOAD: `load_ready`=1. Each `load_valid`&`load_ready` writes `load_data` to gray_mem[load_cnt] and increments `load_cnt`. Accepting byte 63 moves the FSM to SERVE. It also clears `load_cnt`, the 64-bit `wr_mask`, `wr_count`, the last-address register, and all err flags.
- SERVE: `gray_req`=1 at an edge loads gray_mem[`gray_addr`] into `gray_data`. Otherwise `gray_data` holds. `finish`=1 moves to DUMP.
- Write capture in SERVE, on every cycle with `lbp_write`=1:
  - Border address (x∈{0,7} or y∈{0,7}): nothing stored; `err_border` set.
  - Interior address: lbp_mem[`lbp_addr`] ← `lbp_data`; last write wins.
  - A new-write event occurs when `lbp_write` rises, or when `lbp_addr` differs from the last captured address.
  - On a new-write event: if `wr_mask[addr]`=1, set `err_dup`; else set the mask bit and increment `wr_count` (7 bits, saturating at 64).
- DUMP entry: if `wr_count` ≠ 36, set `err_count`. `out_addr` starts at 0 with `out_valid`=1.
  - `out_data` = `wr_mask[out_addr]` ? lbp_mem[out_addr] : 0. Border addresses are always 0.
  - Each `out_valid`&`out_ready` advances `out_addr`. The transfer at address 63 moves the FSM to DONE and deasserts `out_valid`.
- DONE: `done`=1. `clear`=1 moves to LOAD; err flags hold until the next SERVE entry.
- Inputs ignored outside their state: `load_valid` outside LOAD; `gray_req`, `lbp_write`, `finish` outside SERVE; `clear` outside DONE.

## Timing
- Reset values: `load_ready`=1, `gray_data`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `done`=0, all err flags=0, state LOAD. Memory contents are not cleared; `wr_mask` is cleared.
- Outputs are registered. `out_data` is combinational from registered `out_addr` and the memories.
- Read latency is 1 cycle: a request sampled at edge k gives valid `gray_data` after edge k.
- Write capture is 0 cycles: data is visible to the dump from the next edge.
- A write and `finish` on the same edge: the write is captured, then the FSM enters DUMP, with `wr_count` including that write.
- Last load byte to SERVE: 1 edge. `finish` to first `out_valid`: 1 edge.
- A dump with `out_ready` held high takes 64 cycles. `out_ready` low stalls with `out_addr`/`out_data` stable.
- Asserting `reset` mid-operation aborts immediately to LOAD with the reset values above.

## Test plan
- Load bytes 0..63 with gaps in `load_valid`, then `gray_req`=1 at `gray_addr`=0x1B → `gray_data`=27 on the next cycle; `load_ready`=0 in SERVE.
- Write 36 interior addresses with data = addr ^ 0xA5, `lbp_write` held high between writes, then `finish` → dump returns addr^0xA5 at interior addresses and 0 at all 28 border addresses; no err flags; `done`=1 after byte 63.
- Write 0x09 then 0x12 then 0x09 again → `err_dup`=1; the dumped value at 0x09 is the last data written.
- Write to 0x07 → `err_border`=1; dump at 0x07 = 0. Finish after 35 interior writes → `err_count`=1; the unwritten pixel dumps 0.
- Toggle `out_ready` 1-0-0-1 during the dump → no skipped or repeated addresses. `clear` in DONE → LOAD with `load_ready`=1.
- Assert `reset` mid-dump at `out_addr`=20 → all outputs return to reset values; a reload and rerun then behaves normally.
